// File: rtl/clock_period_meter_pkg.sv
// Shared types and defaults for the clock period meter: FSM state encoding,
// default parameter values and the counter width helper.
package clock_period_meter_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   localparam int DEF_MAX_PERIOD  = 1024;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_LOCK_COUNT  = 4;
   localparam int DEF_TOL         = 1;

   // Width that can hold every count from 0 up to and including max_period.
   function automatic int calc_pw(input int max_period);
      return $clog2(max_period + 1);
   endfunction

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by an edge
// register; emits registered one-cycle rise/fall strobes SYNC_STAGES+1 cycles late.
module sync_edge_detect
   import clock_period_meter_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   sync_s;

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         sync_q <= '0;
         edge_q <= 1'b0;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
      end else begin
         // NOTE: non-blocking so every stage samples its neighbour's old value.
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_sig};
         edge_q <= sync_s;
         o_rise <= sync_s & ~edge_q;
         o_fall <= ~sync_s & edge_q;
      end
   end

endmodule

// File: rtl/clock_period_meter.sv
// Measures rise-to-rise period and high time of a slow async signal in i_clk
// cycles, with lock and timeout. Define CLOCK_PERIOD_METER_DUTY_EN to build o_high.
module clock_period_meter
   import clock_period_meter_pkg::*;
#(
   parameter  int MAX_PERIOD  = DEF_MAX_PERIOD,
   parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter  int LOCK_COUNT  = DEF_LOCK_COUNT,
   parameter  int TOL         = DEF_TOL,
   localparam int PW          = calc_pw(MAX_PERIOD)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_sig,
   output logic          o_rise,
   output logic          o_fall,
   output logic [PW-1:0] o_period,
   output logic [PW-1:0] o_high,
   output logic          o_valid,
   output logic          o_locked,
   output logic          o_timeout
);

   localparam int MW = $clog2(LOCK_COUNT + 1);

   state_t        state_q, state_d;
   logic [PW-1:0] cnt;
   logic [PW-1:0] prev_period;
   logic          have_prev;
   logic [MW-1:0] match_cnt, match_next;
   logic [PW:0]   diff;
   logic          is_match;
   logic          do_valid, do_timeout;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_sig  (i_sig),
      .o_rise (o_rise),
      .o_fall (o_fall)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: defaults first so no path through the case infers a latch.
      state_d    = state_q;
      do_valid   = 1'b0;
      do_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (o_rise) state_d = MEASURE;
         end
         MEASURE: begin
            if (o_rise) begin
               do_valid = 1'b1;
            end else if (cnt == PW'(MAX_PERIOD)) begin
               do_timeout = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // One extra bit so the unsigned difference never wraps.
   always_comb begin
      if (cnt >= prev_period) diff = {1'b0, cnt} - {1'b0, prev_period};
      else                    diff = {1'b0, prev_period} - {1'b0, cnt};
      is_match = have_prev && (diff <= (PW+1)'(TOL));
      if (!is_match)                         match_next = '0;
      else if (match_cnt == MW'(LOCK_COUNT)) match_next = match_cnt;
      else                                   match_next = match_cnt + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst)                        cnt <= '0;
      else if (o_rise)                   cnt <= PW'(1);
      else if (cnt != PW'(MAX_PERIOD))   cnt <= cnt + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         o_period    <= '0;
         o_valid     <= 1'b0;
         o_locked    <= 1'b0;
         o_timeout   <= 1'b0;
         prev_period <= '0;
         have_prev   <= 1'b0;
         match_cnt   <= '0;
      end else begin
         o_valid <= do_valid;
         if (o_rise) o_timeout <= 1'b0;
         if (do_valid) begin
            o_period    <= cnt;
            prev_period <= cnt;
            have_prev   <= 1'b1;
            match_cnt   <= match_next;
            o_locked    <= (match_next == MW'(LOCK_COUNT));
         end
         // Signal stopped: forget history so the next valid starts a fresh lock.
         if (do_timeout) begin
            o_timeout <= 1'b1;
            o_locked  <= 1'b0;
            match_cnt <= '0;
            have_prev <= 1'b0;
         end
      end
   end

`ifdef CLOCK_PERIOD_METER_DUTY_EN
   logic [PW-1:0] hi_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         hi_cnt <= '0;
         o_high <= '0;
      end else begin
         if (state_q == MEASURE && o_fall) hi_cnt <= cnt;
         if (do_valid)                     o_high <= hi_cnt;
      end
   end
`else
   assign o_high = '0;
`endif

endmodule
